// File: rtl/mult_fast_param_if.sv
// Start/busy/done handshake bundle for the parametrised sequential multiplier.
// The master side issues operands; the slave side returns status and product.
interface mult_fast_param_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_fast_param.sv
// Sequential unsigned multiplier: one WORD_W x WORD_W partial product per cycle.
// Optional macro ZERO_SKIP_EN skips word pairs where either operand word is zero.
module mult_fast_param #(
    parameter int DATA_W = 32,
    parameter int WORD_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    mult_fast_param_if.slave   bus
);
    localparam int NW     = DATA_W / WORD_W;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   a_r, b_r;
    logic [IDX_W-1:0]    i_r, j_r, i_n, j_n;
    logic [PROD_W-1:0]   product_r;
    logic                busy_r, done_r;
    logic                load, acc;

    logic [WORD_W-1:0]   a_word, b_word;
    logic [2*WORD_W-1:0] pp;
    logic [PROD_W-1:0]   pp_shift;

`ifdef ZERO_SKIP_EN
    function automatic logic [NW-1:0] nz_mask(input logic [DATA_W-1:0] v);
        logic [NW-1:0] m;
        for (int k = 0; k < NW; k++)
            m[k] = |v[k*WORD_W +: WORD_W];
        return m;
    endfunction

    // Lowest set bit at or above 'from'; MSB of the result flags that one was found.
    function automatic logic [IDX_W:0] next_set(input logic [NW-1:0] mask, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = NW - 1; k >= 0; k--)
            if (k >= from && mask[k])
                r = {1'b1, IDX_W'(k)};
        return r;
    endfunction

    logic [NW-1:0]  mask_a, mask_b;
    logic [IDX_W:0] fa, fb, fi, fj, f0;

    assign mask_a = nz_mask(a_r);
    assign mask_b = nz_mask(b_r);
`endif

    assign a_word   = a_r[int'(i_r)*WORD_W +: WORD_W];
    assign b_word   = b_r[int'(j_r)*WORD_W +: WORD_W];
    assign pp       = a_word * b_word;
    assign pp_shift = PROD_W'(pp) << (WORD_W * (int'(i_r) + int'(j_r)));

    always_comb begin
        state_n = state;
        i_n     = i_r;
        j_n     = j_r;
        load    = 1'b0;
        acc     = 1'b0;
`ifdef ZERO_SKIP_EN
        fa = '0;
        fb = '0;
        fi = '0;
        fj = '0;
        f0 = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
`ifdef ZERO_SKIP_EN
                    fa = next_set(nz_mask(bus.a), 0);
                    fb = next_set(nz_mask(bus.b), 0);
                    i_n = fa[IDX_W-1:0];
                    j_n = fb[IDX_W-1:0];
                    state_n = (fa[IDX_W] && fb[IDX_W]) ? CALC : DONE;
`else
                    i_n = '0;
                    j_n = '0;
                    state_n = CALC;
`endif
                end
            end
            CALC: begin
                acc = 1'b1;
`ifdef ZERO_SKIP_EN
                // Advance along A first; wrap to the next non-zero B word.
                fi = next_set(mask_a, int'(i_r) + 1);
                fj = next_set(mask_b, int'(j_r) + 1);
                f0 = next_set(mask_a, 0);
                if (fi[IDX_W]) begin
                    i_n = fi[IDX_W-1:0];
                end else if (fj[IDX_W]) begin
                    i_n = f0[IDX_W-1:0];
                    j_n = fj[IDX_W-1:0];
                end else begin
                    state_n = DONE;
                end
`else
                if (i_r == IDX_W'(NW - 1)) begin
                    i_n = '0;
                    if (j_r == IDX_W'(NW - 1))
                        state_n = DONE;
                    else
                        j_n = j_r + IDX_W'(1);
                end else begin
                    i_n = i_r + IDX_W'(1);
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            i_r       <= '0;
            j_r       <= '0;
            product_r <= '0;
        end else begin
            state  <= state_n;
            busy_r <= (state_n != IDLE);
            done_r <= (state_n == DONE);
            i_r    <= i_n;
            j_r    <= j_n;
            if (load) begin
                a_r       <= bus.a;
                b_r       <= bus.b;
                product_r <= '0;
            end else if (acc) begin
                product_r <= product_r + pp_shift;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_mult_fast_param.sv
// Scoreboard bench for mult_fast_param: stimulus pushes expected results, a monitor pops on done.
module tb_mult_fast_param;
    localparam int DATA_W = 32;
    localparam int WORD_W = 16;
    localparam int NW     = DATA_W / WORD_W;
    localparam int PROD_W = 2 * DATA_W;

    typedef struct {
        logic [PROD_W-1:0] prod;
        int                start_cyc;
        int                done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [PROD_W-1:0] last_exp = '0;
    exp_t sbq[$];

    mult_fast_param_if #(.DATA_W(DATA_W)) bus ();

    mult_fast_param #(.DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of cycles spent accumulating, straight from the pair-count rule.
    function automatic int pairs(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
`ifdef ZERO_SKIP_EN
        int na = 0;
        int nb = 0;
        for (int k = 0; k < NW; k++) begin
            if (((av >> (k * WORD_W)) & ((1 << WORD_W) - 1)) != 0) na++;
            if (((bv >> (k * WORD_W)) & ((1 << WORD_W) - 1)) != 0) nb++;
        end
        return na * nb;
`else
        return NW * NW;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rand_operand();
        logic [DATA_W-1:0] v = '0;
        logic [WORD_W-1:0] w;
        for (int k = 0; k < NW; k++) begin
            case ($urandom_range(0, 3))
                0:       w = '0;
                1:       w = '1;
                default: w = WORD_W'($urandom);
            endcase
            v = v | (DATA_W'(w) << (k * WORD_W));
        end
        return v;
    endfunction

    task automatic issue(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (bus.busy && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("idle_wait", bus.busy, 0);
        if (bus.busy) return;
        check("product_hold", bus.product, last_exp);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        e.prod      = PROD_W'(av) * PROD_W'(bv);
        e.start_cyc = cyc;
        e.done_cyc  = cyc + pairs(av, bv) + 1;
        sbq.push_back(e);
        last_exp = e.prod;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Pulse start with junk operands, but only while the DUT is busy.
    task automatic poke();
        @(negedge clk);
        if (bus.busy) begin
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // Monitor
    initial begin
        logic prev_done = 1'b0;
        exp_t h;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                check("done_with_busy", bus.busy, 1);
                check("done_single_cycle", prev_done, 0);
                check("done_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    h = sbq.pop_front();
                    check("product", bus.product, h.prod);
                    check("done_cycle", cyc, h.done_cyc);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].start_cyc) begin
                check("busy_in_op", bus.busy, 1);
                if (cyc >= sbq[0].done_cyc) begin
                    check("done_missing", cyc, sbq[0].done_cyc - 1);
                    void'(sbq.pop_front());
                end
            end else begin
                check("busy_idle", bus.busy, 0);
            end
            prev_done = bus.done;
        end
    end

    // Stimulus
    initial begin
        int drain;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        reset_n = 1'b1;

        issue(32'h0000_1234, 32'h0000_5678);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32'h0001_0000, 32'h0000_0003);
        issue(32'h0000_0000, 32'hDEAD_BEEF);
        issue(32'h0002_0000, 32'h0003_0000);
        issue(32'hDEAD_BEEF, 32'h0000_0000);

        // Start during CALC is ignored; next start follows done back-to-back.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.a     = 32'h1;
        bus.b     = 32'h1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        issue(32'd3, 32'd5);

        // Asynchronous reset in the middle of an operation.
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        reset_n = 1'b0;
        sbq.delete();
        last_exp = '0;
        #1;
        check("midop_reset_busy", bus.busy, 0);
        check("midop_reset_done", bus.done, 0);
        check("midop_reset_product", bus.product, 0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(32'h1234_5678, 32'h9ABC_DEF0);

        for (int n = 0; n < 150; n++) begin
            issue(rand_operand(), rand_operand());
            repeat ($urandom_range(0, 3)) poke();
        end

        drain = 0;
        while (sbq.size() != 0 && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", sbq.size(), 0);
        @(negedge clk);
        check("final_product_hold", bus.product, last_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_fast_param.md
Name: mult_fast_param

Overview:
Parametrised sequential unsigned multiplier, the successor to the fixed 32x32 fast multiplier FSM. It combines the control FSM and datapath in one block. Operands are split into WORD_W-bit words, and one WORD_W x WORD_W partial product is accumulated per cycle into a 2*DATA_W product register. Partial products with a zero operand word are skipped. The block sits behind a start/busy/done handshake for use by CPU-side or test-harness logic.

Parameters:
DATA_W, 32, operand width in bits; must be an integer multiple of WORD_W and at least WORD_W.
WORD_W, 16, width of one operand word and of the single hardware multiplier.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
start  input  1  request a new multiplication; sampled only in IDLE
a  input  DATA_W  operand A; sampled in the cycle start is accepted
b  input  DATA_W  operand B; sampled in the cycle start is accepted
busy  output  1  high while an operation is in progress (CALC and DONE)
done  output  1  single-cycle pulse; product is valid from this cycle onward
product  output  2*DATA_W  result register; holds its value until the next accepted start

Behaviour:
- NW = DATA_W/WORD_W. Word k of an operand is bits [k*WORD_W +: WORD_W].
- Reset (reset_n=0, asynchronous, any state, including mid-operation):
  - state=IDLE
  - busy=0, done=0, product=0
  - operand registers and indices cleared
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - latch a and b into internal registers; later changes on a/b are ignored
  - clear product to 0
  - compute the pair list and go to CALC; go directly to DONE if the list is empty
- IDLE, start=0: stay in IDLE; product holds.
- Pair list:
  - contains every (i,j) with A word i != 0 and B word j != 0
  - ordering: j (B index) is the outer loop and i (A index) the inner loop, both ascending
  - P = number of pairs = nzA*nzB, where nzA and nzB are the counts of non-zero words
- CALC: one pair per cycle, product <= product + ((A_i*B_j) << (WORD_W*(i+j))).
  - Accumulation is full 2*DATA_W width; no overflow is possible.
  - After the last pair, go to DONE.
  - The next non-zero index is found combinationally, so skipped pairs cost zero cycles.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Timing, with the cycle in which start is accepted as cycle 0:
  - busy=1 in cycles 1..P+1
  - CALC occupies cycles 1..P
  - done=1 in cycle P+1
  - back in IDLE at cycle P+2
  - if P=0 (either operand is zero): done in cycle 1, product=0
- start while busy=1 (CALC or DONE) is ignored and has no side effects.
- start asserted in the cycle after done is accepted normally. The earliest back-to-back start is therefore in cycle P+2.
- done and busy are registered outputs (no combinational path from inputs).

Optional Feature:
Macro ZERO_SKIP_EN.
- Defined: zero-word skipping as above; latency is 1 + nzA*nzB cycles.
- Undefined:
  - all NW*NW pairs are visited in the same j-outer/i-inner order, including zero words
  - P = NW*NW always, giving fixed latency 1 + NW*NW cycles
  - no zero-detect or priority-encoder logic is synthesised
  - the result is identical in both builds

Test Plan:
Defaults DATA_W=32, WORD_W=16, ZERO_SKIP_EN defined.
1. a=0x0000_1234, b=0x0000_5678, start for 1 cycle -> P=1; done in cycle 2; product=0x0000_0000_0626_0060; busy high in cycles 1..2.
2. a=0xFFFF_FFFF, b=0xFFFF_FFFF -> P=4; done in cycle 5; product=0xFFFF_FFFE_0000_0001.
3. a=0x0001_0000, b=0x0000_0003 -> only pair (1,0); P=1; product=0x0000_0003_0000. Rebuild without ZERO_SKIP_EN: P=4, done in cycle 5, same product.
4. a=0, b=0xDEAD_BEEF -> P=0; done in cycle 1; product=0. Then a=0x0002_0000, b=0x0003_0000 -> P=1; product=0x0006_0000_0000.
5. Start a=0xFFFF_FFFF, b=0xFFFF_FFFF; in cycle 2 change a/b to 0x1 and pulse start -> ignored; result still 0xFFFF_FFFE_0000_0001 with done in cycle 5. Next start in cycle 6 with a=3, b=5 -> product=15.
6. Start a=0x1234_5678, b=0x9ABC_DEF0; assert reset_n=0 in cycle 2 -> busy=0, done=0, product=0 immediately. Release reset_n, restart with the same operands -> product=0x0B00_EA4E_242D_2080, done in cycle 5.
